uart_rx: RTL and testbench

UART receiver that recovers bytes from the serial line and hands them to the debug unit's receive path as a data byte plus a one-cycle done strobe. It sits directly upstream of the debug receive FSM: its `o_rx_data` / `o_rx_done` drive that FSM's `i_rx_data` / `i_rx_done`. Frame format is fixed at 8N1, LSB first, line idle high. Bits are sampled with a 16x oversampling tick generated internally from the system clock.

---
 rtl/uart_rx.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a free-running 16x oversampling tick.
// Recovers LSB-first bytes, flags stop-bit framing errors and exposes the
// FSM state for debug. All logic runs on the rising edge of i_clock.
module uart_rx #(
   parameter int N_BITS      = 8,
   parameter int N_TICKS     = 16,
   parameter int N_TICK_DIV  = 163,
   parameter int NB_TICK_DIV = 8,
   parameter int NB_STATE    = 2
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_rx,
   output logic [N_BITS-1:0]   o_rx_data,
   output logic                o_rx_done,
   output logic                o_frame_error,
   output logic                o_busy,
   output logic [NB_STATE-1:0] o_state
);

   localparam logic [NB_STATE-1:0]    ST_IDLE  = NB_STATE'(0);
   localparam logic [NB_STATE-1:0]    ST_START = NB_STATE'(1);
   localparam logic [NB_STATE-1:0]    ST_DATA  = NB_STATE'(2);
   localparam logic [NB_STATE-1:0]    ST_STOP  = NB_STATE'(3);

   localparam logic [NB_TICK_DIV-1:0] DIV_LAST = NB_TICK_DIV'(N_TICK_DIV - 1);
   localparam logic [3:0]             S_MID    = 4'(N_TICKS / 2 - 1);
   localparam logic [3:0]             S_LAST   = 4'(N_TICKS - 1);
   localparam logic [2:0]             N_LAST   = 3'(N_BITS - 1);

   // Two-flop synchronizer on the asynchronous line
   logic                   rx_meta_p0;
   logic                   rx_sync_p1;

   // Oversampling tick divider
   logic [NB_TICK_DIV-1:0] div_q;
   logic                   tick;

   // FSM state, counters, shift register and re-arm flag
   logic [NB_STATE-1:0]    state_q, state_d;
   logic [3:0]             s_q, s_d;
   logic [2:0]             n_q, n_d;
   logic [N_BITS-1:0]      shift_q, shift_d;
   logic                   armed_q, armed_d;

   // Stop-bit decisions feeding the registered strobes
   logic                   done_set;
   logic                   err_set;
   logic [N_BITS-1:0]      rx_data_q;
   logic                   rx_done_q;
   logic                   frame_err_q;

   assign tick = (div_q == DIV_LAST);

   // Synchronize the line and run the free-running tick divider
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         rx_meta_p0 <= 1'b1;
         rx_sync_p1 <= 1'b1;
         div_q      <= '0;
      end else begin
         rx_meta_p0 <= i_rx;
         rx_sync_p1 <= rx_meta_p0;
         if (tick) begin
            div_q <= '0;
         end else begin
            div_q <= div_q + NB_TICK_DIV'(1);
         end
      end
   end

   // FSM state register together with its counters and shift register
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         n_q     <= '0;
         shift_q <= '0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         shift_q <= shift_d;
         armed_q <= armed_d;
      end
   end

   // Next-state logic: start detection, mid-bit sampling and stop handling
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      shift_d = shift_q;
      armed_d = armed_q;
      case (state_q)
         ST_IDLE: begin
            // Only a high line arms the detector, so a held-low break after a
            // framing error cannot be mistaken for a string of start bits.
            if (rx_sync_p1) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               state_d = ST_START;
               s_d     = '0;
               armed_d = 1'b0;
            end
         end
         ST_START: begin
            if (tick) begin
               if (s_q == S_MID) begin
                  if (!rx_sync_p1) begin
                     state_d = ST_DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  s_d = s_q + 4'd1;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (s_q == S_LAST) begin
                  shift_d = {rx_sync_p1, shift_q[N_BITS-1:1]};
                  s_d     = '0;
                  if (n_q == N_LAST) begin
                     state_d = ST_STOP;
                  end else begin
                     n_d = n_q + 3'd1;
                  end
               end else begin
                  s_d = s_q + 4'd1;
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (s_q == S_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  s_d = s_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode: status flags and the stop-bit verdict
   always_comb begin
      o_busy   = (state_q != ST_IDLE);
      o_state  = state_q;
      done_set = 1'b0;
      err_set  = 1'b0;
      if (state_q == ST_STOP && tick && s_q == S_LAST) begin
         done_set = rx_sync_p1;
         err_set  = !rx_sync_p1;
      end
   end

   // Register the byte and one-cycle strobes; data only moves on a good frame
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         rx_data_q   <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_done_q   <= done_set;
         frame_err_q <= err_set;
         if (done_set) begin
            rx_data_q <= shift_q;
         end
      end
   end

   assign o_rx_data     = rx_data_q;
   assign o_rx_done     = rx_done_q;
   assign o_frame_error = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives framed bytes (directed and random, with baud skew) into
// uart_rx and compares every output on every cycle against a frame-level
// model that predicts state spans and strobe cycles from tick arithmetic.
module tb_uart_rx;

   localparam int N    = 4;
   localparam int BLEN = 16 * N;

   logic       i_clock;
   logic       i_reset;
   logic       i_rx;
   logic [7:0] o_rx_data;
   logic       o_rx_done;
   logic       o_frame_error;
   logic       o_busy;
   logic [1:0] o_state;

   uart_rx #(
      .N_BITS      (8),
      .N_TICKS     (16),
      .N_TICK_DIV  (N),
      .NB_TICK_DIV (8),
      .NB_STATE    (2)
   ) dut (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_rx          (i_rx),
      .o_rx_data     (o_rx_data),
      .o_rx_done     (o_rx_done),
      .o_frame_error (o_frame_error),
      .o_busy        (o_busy),
      .o_state       (o_state)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   // Edge counter: after the k-th rising edge, cyc == k
   int cyc = 0;
   always @(posedge i_clock) cyc <= cyc + 1;

   typedef struct {
      int         f3;
      int         s1;
      int         s2;
      int         e;
      bit         glitch;
      bit         good;
      logic [7:0] d;
   } frame_t;

   frame_t     q[$];
   frame_t     h;
   logic [7:0] m_data = 8'h00;
   int         rst_edge = 0;
   bit         chk_en = 1'b0;
   int         checks = 0;
   int         errors = 0;
   int         done_cnt = 0;
   int         err_cnt = 0;
   int         done_times[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h at cyc %0d", name, got, want, cyc);
      end
   endtask

   // First tick-counting edge at or after edge a; ticks land on edges that
   // are a multiple of N past the last reset edge.
   function automatic int first_tick(input int a);
      return a + ((N - ((a - rst_edge) % N)) % N);
   endfunction

   // A frame whose line falls right after edge f: START from f+3, 8 ticks to
   // mid start bit, 8x16 ticks of data, 16 ticks to the stop sample.
   task automatic expect_frame(input int f, input logic [7:0] d, input bit good, input bit glitch);
      frame_t fr;
      int t0;
      t0        = first_tick(f + 4);
      fr.f3     = f + 3;
      fr.s1     = t0 + 7 * N;
      fr.s2     = fr.s1 + 128 * N;
      fr.e      = fr.s1 + 144 * N;
      fr.glitch = glitch;
      fr.good   = good;
      fr.d      = d;
      q.push_back(fr);
   endtask

   task automatic step(input int c);
      repeat (c) begin
         @(posedge i_clock);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop, input int blen, input int cut);
      logic [9:0] bits;
      int lim;
      bits = {stop, d, 1'b0};
      lim  = (cut > 0) ? cut : 10 * blen;
      expect_frame(cyc, d, stop, 1'b0);
      for (int c = 0; c < lim; c++) begin
         i_rx = bits[c / blen];
         step(1);
      end
   endtask

   task automatic send_glitch(input int len);
      expect_frame(cyc, 8'h00, 1'b0, 1'b1);
      i_rx = 1'b0;
      step(len);
      i_rx = 1'b1;
   endtask

   task automatic idle(input int c);
      i_rx = 1'b1;
      step(c);
   endtask

   // Per-cycle comparison of every output against the frame model
   logic [1:0]  es;
   logic        ed, ee;
   logic [12:0] got_v, exp_v;
   always @(negedge i_clock) begin
      if (chk_en) begin
         es = 2'd0;
         ed = 1'b0;
         ee = 1'b0;
         if (q.size() > 0) begin
            h = q[0];
            if (cyc >= h.f3 && cyc < h.s1) es = 2'd1;
            else if (!h.glitch && cyc >= h.s1 && cyc < h.s2) es = 2'd2;
            else if (!h.glitch && cyc >= h.s2 && cyc < h.e) es = 2'd3;
            if (!h.glitch && cyc == h.e) begin
               if (h.good) begin
                  ed     = 1'b1;
                  m_data = h.d;
               end else begin
                  ee = 1'b1;
               end
            end
            if (cyc >= (h.glitch ? h.s1 - 1 : h.e)) void'(q.pop_front());
         end
         got_v = {o_rx_done, o_frame_error, o_busy, o_state, o_rx_data};
         exp_v = {ed, ee, (es != 2'd0), es, m_data};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL outputs at cyc %0d got done=%b err=%b busy=%b state=%0d data=%h want done=%b err=%b busy=%b state=%0d data=%h",
                     cyc, o_rx_done, o_frame_error, o_busy, o_state, o_rx_data,
                     ed, ee, (es != 2'd0), es, m_data);
         end
      end
   end

   // Strobe observations used by the directed literal checks
   always @(negedge i_clock) begin
      if (chk_en) begin
         if (o_rx_done) begin
            done_cnt++;
            done_times.push_back(cyc);
         end
         if (o_frame_error) err_cnt++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, e0, base, diff, blen, gap;
      bit prev_err, stop;
      logic [7:0] rb;

      i_reset = 1'b1;
      i_rx    = 1'b1;
      step(3);
      i_reset  = 1'b0;
      rst_edge = cyc;
      chk_en   = 1'b1;
      chk("reset_outputs", 32'({o_rx_done, o_frame_error, o_busy, o_state, o_rx_data}), 32'h0);
      idle(20);

      // Single byte
      send_frame(8'h55, 1'b1, BLEN, 0);
      idle(100);
      chk("single_done_cnt", 32'(done_cnt), 32'd1);
      chk("single_data", 32'(o_rx_data), 32'h55);
      chk("single_no_err", 32'(err_cnt), 32'd0);

      // Four back-to-back 0xFF bytes
      base = done_times.size();
      repeat (4) send_frame(8'hFF, 1'b1, BLEN, 0);
      idle(100);
      chk("ff_done_cnt", 32'(done_cnt), 32'd5);
      chk("ff_data", 32'(o_rx_data), 32'hFF);
      for (int i = 1; i < 4; i++) begin
         if (base + i < done_times.size()) diff = done_times[base + i] - done_times[base + i - 1];
         else diff = 0;
         chk("ff_spacing", 32'(diff >= 636 && diff <= 644), 32'd1);
      end

      // Start-bit glitch of 3 ticks
      d0 = done_cnt;
      e0 = err_cnt;
      send_glitch(3 * N);
      idle(80);
      chk("glitch_no_done", 32'(done_cnt), 32'(d0));
      chk("glitch_no_err", 32'(err_cnt), 32'(e0));
      chk("glitch_idle", 32'(o_state), 32'd0);

      // Framing error followed by a three-frame break
      send_frame(8'h3C, 1'b1, BLEN, 0);
      idle(50);
      d0 = done_cnt;
      e0 = err_cnt;
      send_frame(8'hA5, 1'b0, BLEN, 0);
      i_rx = 1'b0;
      step(3 * 10 * BLEN);
      idle(100);
      chk("break_one_err", 32'(err_cnt - e0), 32'd1);
      chk("break_no_done", 32'(done_cnt), 32'(d0));
      chk("break_data_held", 32'(o_rx_data), 32'h3C);
      send_frame(8'h01, 1'b1, BLEN, 0);
      idle(100);
      chk("after_break_data", 32'(o_rx_data), 32'h01);
      chk("after_break_done", 32'(done_cnt - d0), 32'd1);

      // Reset in the middle of data bit 4
      d0 = done_cnt;
      send_frame(8'hC3, 1'b1, BLEN, 5 * BLEN + BLEN / 2);
      i_reset = 1'b1;
      i_rx    = 1'b1;
      step(1);
      i_reset  = 1'b0;
      rst_edge = cyc;
      q.delete();
      m_data = 8'h00;
      chk("midreset_outputs", 32'({o_rx_done, o_frame_error, o_busy, o_state, o_rx_data}), 32'h0);
      idle(100);
      chk("midreset_no_done", 32'(done_cnt), 32'(d0));
      send_frame(8'h7E, 1'b1, BLEN, 0);
      idle(100);
      chk("post_reset_data", 32'(o_rx_data), 32'h7E);

      // Baud skew of -3% and +3%
      send_frame(8'h96, 1'b1, 62, 0);
      idle(60);
      chk("skew_fast_data", 32'(o_rx_data), 32'h96);
      send_frame(8'h96, 1'b1, 66, 0);
      idle(60);
      chk("skew_slow_data", 32'(o_rx_data), 32'h96);

      // Random bytes, skews, gaps and occasional bad stop bits
      prev_err = 1'b0;
      for (int k = 0; k < 16; k++) begin
         rb   = 8'($urandom);
         blen = $urandom_range(62, 66);
         stop = ($urandom_range(0, 99) >= 15);
         gap  = prev_err ? $urandom_range(10, 80) : $urandom_range(0, 80);
         idle(gap);
         send_frame(rb, stop, blen, 0);
         prev_err = !stop;
      end
      idle(800);
      chk("model_drained", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
